// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master between NREQ requesters.
// One transaction at a time; the grant is held until SPI_done or a watchdog timeout.
module spi_arbiter #(
    parameter int NREQ      = 3,
    parameter int TO_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [16*NREQ-1:0]  req_data,
    input  logic [3*NREQ-1:0]   req_ss,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic [7:0]          rd_data,
    output logic                timeout_err,
    input  logic                err_clr,
    output logic                busy,
    output logic [15:0]         SPI_data,
    output logic                wrt_SPI,
    output logic [2:0]          ss,
    input  logic                SPI_done,
    input  logic [7:0]          EEP_data
);

    localparam int PW = (NREQ > 2) ? 2 : 1;
    localparam int CW = $clog2(TO_CYCLES);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, FINISH} state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   ptr_reg, ptr_next;
    logic [PW-1:0]   owner_reg, owner_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [NREQ-1:0] gnt_reg, gnt_next;
    logic [NREQ-1:0] done_reg, done_next;
    logic [7:0]      rd_data_reg, rd_data_next;
    logic            timeout_err_reg, timeout_err_next;
    logic            busy_reg, busy_next;
    logic [15:0]     spi_data_reg, spi_data_next;
    logic            wrt_reg, wrt_next;
    logic [2:0]      ss_reg, ss_next;

    logic [15:0]     data_arr [NREQ];
    logic [2:0]      ss_arr   [NREQ];
    logic [PW-1:0]   win_idx;
    logic            expired;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign data_arr[gi] = req_data[16*gi +: 16];
            assign ss_arr[gi]   = req_ss[3*gi +: 3];
        end
    endgenerate

    assign expired = (cnt_reg == CW'(TO_CYCLES - 1));

    // First set request scanning upward from the last owner, wrapping around.
    always_comb begin
        win_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            int cand;
            cand = (int'(ptr_reg) + k) % NREQ;
            if (req[cand]) win_idx = PW'(cand);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            ptr_reg         <= PW'(NREQ - 1);
            owner_reg       <= '0;
            cnt_reg         <= '0;
            gnt_reg         <= '0;
            done_reg        <= '0;
            rd_data_reg     <= '0;
            timeout_err_reg <= 1'b0;
            busy_reg        <= 1'b0;
            spi_data_reg    <= '0;
            wrt_reg         <= 1'b0;
            ss_reg          <= '0;
        end else begin
            state_reg       <= state_next;
            ptr_reg         <= ptr_next;
            owner_reg       <= owner_next;
            cnt_reg         <= cnt_next;
            gnt_reg         <= gnt_next;
            done_reg        <= done_next;
            rd_data_reg     <= rd_data_next;
            timeout_err_reg <= timeout_err_next;
            busy_reg        <= busy_next;
            spi_data_reg    <= spi_data_next;
            wrt_reg         <= wrt_next;
            ss_reg          <= ss_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (|req) state_next = LAUNCH;
            LAUNCH:  state_next = WAIT;
            WAIT:    if (SPI_done || expired) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values for the registered outputs; SPI_data/ss hold between transactions.
    always_comb begin
        ptr_next         = ptr_reg;
        owner_next       = owner_reg;
        cnt_next         = cnt_reg;
        gnt_next         = gnt_reg;
        done_next        = '0;
        rd_data_next     = rd_data_reg;
        timeout_err_next = err_clr ? 1'b0 : timeout_err_reg;
        spi_data_next    = spi_data_reg;
        wrt_next         = 1'b0;
        ss_next          = ss_reg;
        busy_next        = (state_next != IDLE);
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    owner_next    = win_idx;
                    gnt_next      = NREQ'(1) << win_idx;
                    spi_data_next = data_arr[win_idx];
                    ss_next       = ss_arr[win_idx];
                    wrt_next      = 1'b1;
                end
            end
            LAUNCH: cnt_next = '0;
            WAIT: begin
                if (SPI_done) begin
                    rd_data_next = EEP_data;
                    done_next    = gnt_reg;
                end else if (expired) begin
                    rd_data_next     = 8'h00;
                    done_next        = gnt_reg;
                    timeout_err_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            FINISH: begin
                gnt_next = '0;
                ptr_next = owner_reg;
            end
            default: ;
        endcase
    end

    assign gnt         = gnt_reg;
    assign done        = done_reg;
    assign rd_data     = rd_data_reg;
    assign timeout_err = timeout_err_reg;
    assign busy        = busy_reg;
    assign SPI_data    = spi_data_reg;
    assign wrt_SPI     = wrt_reg;
    assign ss          = ss_reg;

endmodule
